// File: rtl/muldiv_hilo_unit_pkg.sv
// Shared ALU-op codes, muldiv FSM state encodings and small opcode decode helpers.
package muldiv_hilo_unit_pkg;

    localparam logic [7:0] ALUOP_MFHI  = 8'h10;
    localparam logic [7:0] ALUOP_MTHI  = 8'h11;
    localparam logic [7:0] ALUOP_MFLO  = 8'h12;
    localparam logic [7:0] ALUOP_MTLO  = 8'h13;
    localparam logic [7:0] ALUOP_MULT  = 8'h18;
    localparam logic [7:0] ALUOP_MULTU = 8'h19;
    localparam logic [7:0] ALUOP_DIV   = 8'h1A;
    localparam logic [7:0] ALUOP_DIVU  = 8'h1B;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_DONE = 2'b10
    } md_state_t;

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == ALUOP_DIV) || (op == ALUOP_DIVU);
    endfunction

    function automatic logic is_mul_op(input logic [7:0] op);
        return (op == ALUOP_MULT) || (op == ALUOP_MULTU);
    endfunction

    function automatic logic is_signed_op(input logic [7:0] op);
        return (op == ALUOP_DIV) || (op == ALUOP_MULT);
    endfunction

endpackage

// File: rtl/muldiv_hilo_unit_div_radix2_core.sv
// div_radix2_core: unsigned radix-2 engine (restoring divide or shift-add multiply), one step per i_step.
// o_hi/o_lo show the values the current step produces, so the caller can capture the final step directly.
module div_radix2_core #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_step,
    input  logic             i_clear,
    input  logic             i_mul,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // r_hi: partial remainder / product high half; r_lo: quotient-dividend / multiplier-product low half
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic             r_mul;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH:0]   w_sh;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_sum;

    assign w_sh   = {r_hi, r_lo[WIDTH-1]};
    assign w_diff = w_sh - {1'b0, r_b};
    assign w_sum  = {1'b0, r_hi} + ({(WIDTH+1){r_lo[0]}} & {1'b0, r_b});
    assign o_last = (r_cnt == LAST);

    always_comb begin
        o_hi = w_sh[WIDTH-1:0];
        o_lo = {r_lo[WIDTH-2:0], 1'b0};
        if (r_mul) begin
            o_hi = w_sum[WIDTH:1];
            o_lo = {w_sum[0], r_lo[WIDTH-1:1]};
        end else if (!w_diff[WIDTH]) begin
            o_hi = w_diff[WIDTH-1:0];
            o_lo = {r_lo[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_b   <= '0;
            r_mul <= 1'b0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_hi  <= '0;
            r_lo  <= i_a;
            r_b   <= i_b;
            r_mul <= i_mul;
            r_cnt <= '0;
        end else if (i_step) begin
            r_hi  <= o_hi;
            r_lo  <= o_lo;
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: E-stage MULT/DIV unit owning HI/LO, serving MFHI/MFLO and requesting stalls.
// Define MULDIV_FAST_MULT_EN for a single-cycle multiplier; division always stays iterative.
module muldiv_hilo_unit
    import muldiv_hilo_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       aluopE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             stallE,
    input  logic             flushE,
    output logic             stall_o,
    output logic [WIDTH-1:0] hilo_rdata,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    md_state_t          r_state;
    md_state_t          w_state_nxt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_is_mul;
    logic               r_q_neg;
    logic               r_r_neg;

    logic               w_is_div;
    logic               w_is_mul;
    logic               w_signed;
    logic               w_iter;
    logic               w_start;
    logic               w_div0;
    logic               w_go;
    logic               w_idle_wr;
    logic               w_step;
    logic               w_last;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH-1:0]   w_core_hi;
    logic [WIDTH-1:0]   w_core_lo;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_prod_u;
    logic [2*WIDTH-1:0] w_prod;

    assign w_is_div = is_div_op(aluopE);
    assign w_is_mul = is_mul_op(aluopE);
    assign w_signed = is_signed_op(aluopE);

`ifdef MULDIV_FAST_MULT_EN
    assign w_iter = w_is_div;
`else
    assign w_iter = w_is_div | w_is_mul;
`endif

    // rst gates start so an opcode held during reset cannot raise a stall request
    assign w_start   = rst && (r_state == MD_IDLE) && (w_is_div || w_is_mul) && !flushE;
    assign w_div0    = w_start && w_is_div && (srcbE == '0);
    assign w_go      = w_start && w_iter && !w_div0;
    assign w_idle_wr = rst && (r_state == MD_IDLE) && !stallE && !flushE;
    assign w_step    = (r_state == MD_RUN) && !flushE;
    assign stall_o   = (w_start && w_iter) || (r_state == MD_RUN);

    assign w_a_neg = w_signed && srcaE[WIDTH-1];
    assign w_b_neg = w_signed && srcbE[WIDTH-1];
    assign w_a_abs = w_a_neg ? -srcaE : srcaE;
    assign w_b_abs = w_b_neg ? -srcbE : srcbE;

    div_radix2_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_start (w_go),
        .i_step  (w_step),
        .i_clear (flushE),
        .i_mul   (w_is_mul),
        .i_a     (w_a_abs),
        .i_b     (w_b_abs),
        .o_last  (w_last),
        .o_hi    (w_core_hi),
        .o_lo    (w_core_lo)
    );

    // Quotient/product sign follows operand sign mismatch; remainder follows the dividend
    assign w_prod_u = {w_core_hi, w_core_lo};
    assign w_prod   = r_q_neg ? -w_prod_u : w_prod_u;
    assign w_quo    = r_q_neg ? -w_core_lo : w_core_lo;
    assign w_rem    = r_r_neg ? -w_core_hi : w_core_hi;

`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] w_fast_u;
    logic [2*WIDTH-1:0] w_fast;
    assign w_fast_u = {{WIDTH{1'b0}}, w_a_abs} * {{WIDTH{1'b0}}, w_b_abs};
    assign w_fast   = (w_a_neg ^ w_b_neg) ? -w_fast_u : w_fast_u;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            MD_IDLE: begin
                if (w_div0) begin
                    w_state_nxt = MD_DONE;
                end else if (w_go) begin
                    w_state_nxt = MD_RUN;
                end
            end
            MD_RUN:  if (w_last) w_state_nxt = MD_DONE;
            MD_DONE: if (!stallE) w_state_nxt = MD_IDLE;
            default: w_state_nxt = MD_IDLE;
        endcase
        if (flushE) begin
            w_state_nxt = MD_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_is_mul <= 1'b0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
        end else if (w_go) begin
            r_is_mul <= w_is_mul;
            r_q_neg  <= w_a_neg ^ w_b_neg;
            r_r_neg  <= w_a_neg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_step && w_last) begin
            if (r_is_mul) begin
                r_hi <= w_prod[2*WIDTH-1:WIDTH];
                r_lo <= w_prod[WIDTH-1:0];
            end else begin
                r_hi <= w_rem;
                r_lo <= w_quo;
            end
        end else if (w_div0) begin
            r_hi <= srcaE;
            r_lo <= '1;
        end else if (w_idle_wr) begin
            if (aluopE == ALUOP_MTHI) r_hi <= srcaE;
            if (aluopE == ALUOP_MTLO) r_lo <= srcaE;
`ifdef MULDIV_FAST_MULT_EN
            if (w_is_mul) begin
                r_hi <= w_fast[2*WIDTH-1:WIDTH];
                r_lo <= w_fast[WIDTH-1:0];
            end
`endif
        end
    end

    always_comb begin
        hilo_rdata = '0;
        if (aluopE == ALUOP_MFHI) begin
            hilo_rdata = r_hi;
        end else if (aluopE == ALUOP_MFLO) begin
            hilo_rdata = r_lo;
        end
    end

    assign hi_o = r_hi;
    assign lo_o = r_lo;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Self-checking bench for muldiv_hilo_unit: vector table, directed corner sequences, random ops vs. an arithmetic model.
module tb_muldiv_hilo_unit;
    import muldiv_hilo_unit_pkg::*;

    localparam int W          = 32;
    localparam int ITER_STALL = W + 1;
`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_STALL  = 0;
`else
    localparam int MUL_STALL  = W + 1;
`endif
    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_BAD = 8'hFF;
    localparam int NVEC = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   aluopE;
    logic [W-1:0] srcaE;
    logic [W-1:0] srcbE;
    logic         stallE;
    logic         flushE;
    logic         stall_o;
    logic [W-1:0] hilo_rdata;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] exp_q[$];

    typedef struct {
        logic [7:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           stalls;
    } vec_t;
    vec_t vecs[NVEC];

    muldiv_hilo_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .aluopE     (aluopE),
        .srcaE      (srcaE),
        .srcbE      (srcbE),
        .stallE     (stallE),
        .flushE     (flushE),
        .stall_o    (stall_o),
        .hilo_rdata (hilo_rdata),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; {HI,LO} packed as one value
    function automatic logic [2*W-1:0] model(input logic [7:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint sa, sb, sq, sr;
        logic [2*W-1:0] ua, ub, uq, ur, res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {{W{1'b0}}, a};
        ub  = {{W{1'b0}}, b};
        res = '0;
        if (op == ALUOP_MULT) begin
            res = sa * sb;
        end else if (op == ALUOP_MULTU) begin
            res = ua * ub;
        end else if (b == '0) begin
            res = {a, {W{1'b1}}};
        end else if (op == ALUOP_DIV) begin
            sq  = sa / sb;
            sr  = sa % sb;
            res = {sr[W-1:0], sq[W-1:0]};
        end else begin
            uq  = ua / ub;
            ur  = ua % ub;
            res = {ur[W-1:0], uq[W-1:0]};
        end
        return res;
    endfunction

    function automatic int exp_stalls(input logic [7:0] op, input logic [W-1:0] b);
        if (is_div_op(op)) return (b == '0) ? 1 : ITER_STALL;
        return MUL_STALL;
    endfunction

    // Issue one MULT/DIV instruction, count stall cycles, optionally hold it in DONE with stallE
    task automatic run_op(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, output int stalls);
        stalls = 0;
        @(negedge clk);
        aluopE = op; srcaE = a; srcbE = b; stallE = 1'b0; flushE = 1'b0;
        #1;
        while (stall_o === 1'b1 && stalls < 200) begin
            stalls++;
            @(negedge clk); #1;
        end
        if (stalls >= 200) begin
            checks++; errors++;
            $display("FAIL stall_timeout actual=%0d expected<200", stalls);
        end
        if (stalls == 0) begin
            @(negedge clk); #1;
        end
        for (int k = 0; k < hold; k++) begin
            stallE = 1'b1;
            @(negedge clk); #1;
            check($sformatf("done_hold%0d_stall", k), {63'd0, stall_o}, 64'd0);
        end
        stallE = 1'b0;
        aluopE = OP_NOP;
        @(negedge clk); #1;
    endtask

    task automatic preset_hilo(input logic [W-1:0] h, input logic [W-1:0] l);
        @(negedge clk); aluopE = ALUOP_MTHI; srcaE = h; stallE = 1'b0; flushE = 1'b0;
        @(negedge clk); aluopE = ALUOP_MTLO; srcaE = l;
        @(negedge clk); aluopE = OP_NOP;
    endtask

    // Start a DIV, flush it while the RUN counter equals k; HI/LO must not change
    task automatic flush_at(input int k);
        preset_hilo(32'h1111, 32'h2222);
        aluopE = ALUOP_DIV; srcaE = 32'd1000; srcbE = 32'd7;
        repeat (k + 1) @(negedge clk);
        flushE = 1'b1;
        @(negedge clk);
        flushE = 1'b0; aluopE = OP_NOP;
        #1;
        check($sformatf("flush%0d_stall", k), {63'd0, stall_o}, 64'd0);
        check($sformatf("flush%0d_hi", k), hi_o, 32'h1111);
        check($sformatf("flush%0d_lo", k), lo_o, 32'h2222);
        repeat (40) @(negedge clk);
        #1;
        check($sformatf("flush%0d_late_hilo", k), {hi_o, lo_o}, {32'h1111, 32'h2222});
    endtask

    initial begin
        int n;
        logic [7:0]   rop;
        logic [W-1:0] ra, rb;
        logic [2*W-1:0] e;

        vecs[0] = '{ALUOP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, ITER_STALL};
        vecs[1] = '{ALUOP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, ITER_STALL};
        vecs[2] = '{ALUOP_DIV,   32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1};
        vecs[3] = '{ALUOP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, MUL_STALL};
        vecs[4] = '{ALUOP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, ITER_STALL};
        vecs[5] = '{ALUOP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_STALL};
        vecs[6] = '{ALUOP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, ITER_STALL};
        vecs[7] = '{ALUOP_DIVU,  32'h00000005, 32'h00000007, 32'h00000005, 32'h00000000, ITER_STALL};
        vecs[8] = '{ALUOP_DIVU,  32'hCAFEF00D, 32'h00000000, 32'hCAFEF00D, 32'hFFFFFFFF, 1};
        vecs[9] = '{ALUOP_MULT,  32'hFFFFFFFB, 32'hFFFFFFF9, 32'h00000000, 32'h00000023, MUL_STALL};

        // Reset with an iterative opcode already presented
        rst = 1'b0; aluopE = ALUOP_DIV; srcaE = 32'h55; srcbE = 32'h3; stallE = 1'b0; flushE = 1'b0;
        #1;
        check("reset_hi", hi_o, 32'h0);
        check("reset_lo", lo_o, 32'h0);
        check("reset_stall", {63'd0, stall_o}, 64'd0);
        repeat (2) @(negedge clk);
        aluopE = OP_NOP; rst = 1'b1;
        #1;
        check("post_reset_stall", {63'd0, stall_o}, 64'd0);

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, n);
            check($sformatf("vec%0d_stalls", i), n, vecs[i].stalls);
            check($sformatf("vec%0d_hi", i), hi_o, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), lo_o, vecs[i].lo);
        end

        // MTHI/MTLO/MFHI/MFLO, flushed and stalled writes, unknown opcode
        @(negedge clk); aluopE = ALUOP_MTHI; srcaE = 32'h1234;
        @(negedge clk); aluopE = ALUOP_MFHI; srcaE = 32'hDEADBEEF; #1;
        check("mfhi_rdata", hilo_rdata, 32'h1234);
        check("mthi_hi", hi_o, 32'h1234);
        @(negedge clk); aluopE = ALUOP_MTLO; srcaE = 32'hABCD;
        @(negedge clk); aluopE = ALUOP_MFLO; #1;
        check("mflo_rdata", hilo_rdata, 32'hABCD);
        @(negedge clk); aluopE = ALUOP_MTLO; srcaE = 32'h5555; flushE = 1'b1;
        @(negedge clk); flushE = 1'b0; aluopE = ALUOP_MFLO; #1;
        check("mtlo_flushed_lo", lo_o, 32'hABCD);
        @(negedge clk); aluopE = ALUOP_MTHI; srcaE = 32'h7777; stallE = 1'b1;
        @(negedge clk); stallE = 1'b0; aluopE = ALUOP_MFHI; #1;
        check("mthi_stalled_rdata", hilo_rdata, 32'h1234);
        aluopE = OP_BAD; #1;
        check("bad_op_rdata", hilo_rdata, 32'h0);
        check("bad_op_stall", {63'd0, stall_o}, 64'd0);
        @(negedge clk); #1;
        check("bad_op_hilo", {hi_o, lo_o}, {32'h1234, 32'hABCD});
        aluopE = OP_NOP;

        // Completion held in DONE by stallE for 3 extra cycles: -100 / 7 = -14 rem -2
        run_op(ALUOP_DIV, 32'hFFFFFF9C, 32'd7, 3, n);
        check("hold_stalls", n, ITER_STALL);
        check("hold_hi", hi_o, 32'hFFFFFFFE);
        check("hold_lo", lo_o, 32'hFFFFFFF2);

        flush_at(10);
        flush_at(W - 1);

        // Asynchronous reset while RUN
        preset_hilo(32'h0BAD, 32'h0F00);
        aluopE = ALUOP_DIV; srcaE = 32'd1000; srcbE = 32'd3;
        repeat (6) @(negedge clk);
        #1;
        check("mid_run_stall", {63'd0, stall_o}, 64'd1);
        rst = 1'b0;
        #1;
        check("async_reset_hilo", {hi_o, lo_o}, 64'd0);
        check("async_reset_stall", {63'd0, stall_o}, 64'd0);
        @(negedge clk); aluopE = OP_NOP; rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("after_reset_hilo", {hi_o, lo_o}, 64'd0);
        check("after_reset_stall", {63'd0, stall_o}, 64'd0);

        // Random MULT/MULTU/DIV/DIVU against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       rop = ALUOP_MULT;
                1:       rop = ALUOP_MULTU;
                2:       rop = ALUOP_DIV;
                default: rop = ALUOP_DIVU;
            endcase
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) rb = '0;
            else if ($urandom_range(0, 1) == 1) rb = $urandom;
            else rb = $urandom_range(1, 300);
            exp_q.push_back(model(rop, ra, rb));
            run_op(rop, ra, rb, 0, n);
            e = exp_q.pop_front();
            check($sformatf("rand%0d_op%h_stalls", i, rop), n, exp_stalls(rop, rb));
            check($sformatf("rand%0d_op%h_a%h_b%h_hilo", i, rop, ra, rb), {hi_o, lo_o}, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
